sensor_cmd_ctrl: RTL and testbench

Command sequencer between the serial receiver/transmitter pair and the sensor interface. Collects a two-byte command frame (command, sensor address) from `uart_rx`, validates it, issues one request to the addressed sensor, waits for the sensor's answer with a timeout, and returns a two-byte response frame (code, data) through `uart_tx`. It is the only owner of the transmitter and of the sensor request bus, and serializes all transactions.

---
 rtl/sensor_cmd_ctrl.sv | 180 ++++++++++++++++++
 tb/tb_sensor_cmd_ctrl.sv | 371 +++++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/sensor_cmd_ctrl.sv
`timescale 1ns/1ps
// Command sequencer between the UART pair and the sensor bus: collects a
// (command, address) frame, runs one sensor transaction and answers (code, data).
// state    | meaning
// IDLE     | wait for command byte
// GET_ADDR | wait for address byte, byte timeout armed
// CHECK    | validate command and address
// REQ      | raise sensor request
// WAIT_ACK | wait for acknowledge, response timeout armed
// TX0/TX1  | start code / data byte once the transmitter is idle
// WAIT0/1  | wait for transmitter done
module sensor_cmd_ctrl #(
   parameter int unsigned NUM_SENSORS  = 32,
   parameter int unsigned BYTE_TIMEOUT = 5_000_000,
   parameter int unsigned RESP_TIMEOUT = 50_000
) (
   input  logic       Clock,
   input  logic       Reset,
   input  logic       i_Rx_DV,
   input  logic [7:0] i_Rx_Byte,
   output logic       o_Tx_DV,
   output logic [7:0] o_Tx_Byte,
   input  logic       i_Tx_Active,
   input  logic       i_Tx_Done,
   output logic       o_Sensor_Req,
   output logic [4:0] o_Sensor_Addr,
   output logic [7:0] o_Sensor_Cmd,
   input  logic       i_Sensor_Ack,
   input  logic [7:0] i_Sensor_Data,
   input  logic       i_Sensor_Err,
   output logic       o_Busy
);

   typedef enum logic [3:0] {
      S_IDLE, S_GET_ADDR, S_CHECK, S_REQ, S_WAIT_ACK, S_TX0, S_WAIT0, S_TX1, S_WAIT1
   } state_t;

   localparam logic [7:0] CODE_BAD_CMD  = 8'hFE;
   localparam logic [7:0] CODE_BAD_ADDR = 8'hFF;
   localparam logic [7:0] CODE_FAULT    = 8'h1F;
   localparam logic [8:0] NUM_LIM       = 9'(NUM_SENSORS);
   localparam logic [31:0] BYTE_LIM = (BYTE_TIMEOUT > 0) ? 32'(BYTE_TIMEOUT - 1) : 32'd0;
   // The request flop lags the state by one cycle, so WAIT_ACK is left one
   // cycle early to keep the request high for exactly RESP_TIMEOUT cycles.
   localparam logic [31:0] RESP_LIM = (RESP_TIMEOUT > 1) ? 32'(RESP_TIMEOUT - 2) : 32'd0;

   state_t      state_q, state_d;
   logic [31:0] cnt_q, cnt_d;
   logic [7:0]  cmd_byte_q, cmd_byte_d;
   logic [7:0]  addr_byte_q, addr_byte_d;
   logic [7:0]  resp_code_q, resp_code_d;
   logic [7:0]  resp_data_q, resp_data_d;
   logic        tx_dv_q, tx_dv_d;
   logic [7:0]  tx_byte_q, tx_byte_d;
   logic        sensor_req_q, sensor_req_d;
   logic [4:0]  sensor_addr_q, sensor_addr_d;
   logic [7:0]  sensor_cmd_q, sensor_cmd_d;
   logic        busy_q, busy_d;
   logic        cmd_ok, addr_ok;

   assign cmd_ok  = (cmd_byte_q <= 8'h02);
   assign addr_ok = ({1'b0, addr_byte_q} < NUM_LIM);

   always_comb begin
      state_d       = state_q;
      cnt_d         = (cnt_q == 32'hFFFF_FFFF) ? cnt_q : cnt_q + 32'd1;
      cmd_byte_d    = cmd_byte_q;
      addr_byte_d   = addr_byte_q;
      resp_code_d   = resp_code_q;
      resp_data_d   = resp_data_q;
      tx_dv_d       = 1'b0;
      tx_byte_d     = tx_byte_q;
      sensor_addr_d = sensor_addr_q;
      sensor_cmd_d  = sensor_cmd_q;

      case (state_q)
         S_IDLE: begin
            if (i_Rx_DV) begin
               cmd_byte_d = i_Rx_Byte;
               state_d    = S_GET_ADDR;
            end
         end
         S_GET_ADDR: begin
            if (i_Rx_DV) begin
               addr_byte_d = i_Rx_Byte;
               state_d     = S_CHECK;
            end else if (cnt_q >= BYTE_LIM) begin
               state_d = S_IDLE;
            end
         end
         S_CHECK: begin
            if (!cmd_ok) begin
               resp_code_d = CODE_BAD_CMD;
               resp_data_d = 8'h00;
               state_d     = S_TX0;
            end else if (!addr_ok) begin
               resp_code_d = CODE_BAD_ADDR;
               resp_data_d = 8'h00;
               state_d     = S_TX0;
            end else begin
               sensor_addr_d = addr_byte_q[4:0];
               sensor_cmd_d  = cmd_byte_q;
               state_d       = S_REQ;
            end
         end
         S_REQ: state_d = S_WAIT_ACK;
         S_WAIT_ACK: begin
            if (i_Sensor_Ack) begin
               resp_code_d = i_Sensor_Err ? CODE_FAULT : cmd_byte_q;
               resp_data_d = i_Sensor_Err ? 8'h00 : i_Sensor_Data;
               state_d     = S_TX0;
            end else if (cnt_q >= RESP_LIM) begin
               resp_code_d = CODE_FAULT;
               resp_data_d = 8'h00;
               state_d     = S_TX0;
            end
         end
         S_TX0: begin
            if (!i_Tx_Active) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = resp_code_q;
               state_d   = S_WAIT0;
            end
         end
         S_WAIT0: if (i_Tx_Done) state_d = S_TX1;
         S_TX1: begin
            if (!i_Tx_Active) begin
               tx_dv_d   = 1'b1;
               tx_byte_d = resp_data_q;
               state_d   = S_WAIT1;
            end
         end
         S_WAIT1: if (i_Tx_Done) state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (state_d != state_q) cnt_d = 32'd0;

      sensor_req_d = (state_q == S_REQ) || (state_q == S_WAIT_ACK);
      busy_d       = !((state_q == S_IDLE) || (state_q == S_GET_ADDR));
   end

   always_ff @(posedge Clock or posedge Reset) begin
      if (Reset) begin
         state_q       <= S_IDLE;
         cnt_q         <= 32'd0;
         cmd_byte_q    <= 8'h00;
         addr_byte_q   <= 8'h00;
         resp_code_q   <= 8'h00;
         resp_data_q   <= 8'h00;
         tx_dv_q       <= 1'b0;
         tx_byte_q     <= 8'h00;
         sensor_req_q  <= 1'b0;
         sensor_addr_q <= 5'd0;
         sensor_cmd_q  <= 8'h00;
         busy_q        <= 1'b0;
      end else begin
         state_q       <= state_d;
         cnt_q         <= cnt_d;
         cmd_byte_q    <= cmd_byte_d;
         addr_byte_q   <= addr_byte_d;
         resp_code_q   <= resp_code_d;
         resp_data_q   <= resp_data_d;
         tx_dv_q       <= tx_dv_d;
         tx_byte_q     <= tx_byte_d;
         sensor_req_q  <= sensor_req_d;
         sensor_addr_q <= sensor_addr_d;
         sensor_cmd_q  <= sensor_cmd_d;
         busy_q        <= busy_d;
      end
   end

   assign o_Tx_DV       = tx_dv_q;
   assign o_Tx_Byte     = tx_byte_q;
   assign o_Sensor_Req  = sensor_req_q;
   assign o_Sensor_Addr = sensor_addr_q;
   assign o_Sensor_Cmd  = sensor_cmd_q;
   assign o_Busy        = busy_q;

endmodule

// File: tb/tb_sensor_cmd_ctrl.sv
`timescale 1ns/1ps
// Bench for sensor_cmd_ctrl: scoreboard of expected response bytes, a simple
// transmitter model and per-scenario tasks driving frames and sensor answers.
module tb_sensor_cmd_ctrl;
   localparam int NS = 32;
   localparam int BT = 1000;
   localparam int RT = 100;

   logic       Clock = 1'b0;
   logic       Reset;
   logic       i_Rx_DV;
   logic [7:0] i_Rx_Byte;
   logic       o_Tx_DV;
   logic [7:0] o_Tx_Byte;
   logic       i_Tx_Active;
   logic       i_Tx_Done;
   logic       o_Sensor_Req;
   logic [4:0] o_Sensor_Addr;
   logic [7:0] o_Sensor_Cmd;
   logic       i_Sensor_Ack;
   logic [7:0] i_Sensor_Data;
   logic       i_Sensor_Err;
   logic       o_Busy;

   int         checks = 0;
   int         errors = 0;
   int         cyc = 0;
   int         tx_extra = 0;
   logic [7:0] exp_q[$];
   logic [7:0] exp_b;
   int         dv_cycs[$];
   int         done_cycs[$];

   sensor_cmd_ctrl #(.NUM_SENSORS(NS), .BYTE_TIMEOUT(BT), .RESP_TIMEOUT(RT)) dut (
      .Clock(Clock), .Reset(Reset),
      .i_Rx_DV(i_Rx_DV), .i_Rx_Byte(i_Rx_Byte),
      .o_Tx_DV(o_Tx_DV), .o_Tx_Byte(o_Tx_Byte),
      .i_Tx_Active(i_Tx_Active), .i_Tx_Done(i_Tx_Done),
      .o_Sensor_Req(o_Sensor_Req), .o_Sensor_Addr(o_Sensor_Addr), .o_Sensor_Cmd(o_Sensor_Cmd),
      .i_Sensor_Ack(i_Sensor_Ack), .i_Sensor_Data(i_Sensor_Data), .i_Sensor_Err(i_Sensor_Err),
      .o_Busy(o_Busy)
   );

   always #5 Clock = ~Clock;
   always @(posedge Clock) cyc <= cyc + 1;

   // scoreboard: every transmitted byte must match the next expected one
   initial begin
      forever begin
         @(negedge Clock);
         if (o_Tx_DV === 1'b1) begin
            dv_cycs.push_back(cyc);
            checks++;
            if (exp_q.size() == 0) begin
               errors++;
               $display("FAIL tx_unexpected got %02h want no byte", o_Tx_Byte);
            end else begin
               exp_b = exp_q.pop_front();
               if (o_Tx_Byte !== exp_b) begin
                  errors++;
                  $display("FAIL tx_byte got %02h want %02h", o_Tx_Byte, exp_b);
               end
            end
         end
      end
   end

   // transmitter model: busy for a few cycles, then a done pulse
   initial begin
      i_Tx_Active = 1'b0;
      i_Tx_Done   = 1'b0;
      forever begin
         @(negedge Clock);
         if (o_Tx_DV === 1'b1) begin
            i_Tx_Active = 1'b1;
            repeat (3) @(negedge Clock);
            i_Tx_Done = 1'b1;
            done_cycs.push_back(cyc);
            @(negedge Clock);
            i_Tx_Done = 1'b0;
            repeat (tx_extra) @(negedge Clock);
            i_Tx_Active = 1'b0;
         end
      end
   end

   initial begin
      #1_000_000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   task automatic send_byte(input logic [7:0] b);
      @(negedge Clock);
      i_Rx_DV   = 1'b1;
      i_Rx_Byte = b;
      @(negedge Clock);
      i_Rx_DV   = 1'b0;
   endtask

   task automatic check_outputs_zero(input string name);
      checks++;
      if ({o_Tx_DV, o_Tx_Byte, o_Sensor_Req, o_Sensor_Addr, o_Sensor_Cmd, o_Busy} !== 23'd0) begin
         errors++;
         $display("FAIL %s got dv=%b byte=%02h req=%b addr=%0d cmd=%02h busy=%b want all 0",
                  name, o_Tx_DV, o_Tx_Byte, o_Sensor_Req, o_Sensor_Addr, o_Sensor_Cmd, o_Busy);
      end
   endtask

   task automatic do_frame(input logic [7:0] cmd, input logic [7:0] addr, input int gap,
                           input int ack_after, input logic err, input logic [7:0] data,
                           input bit inject);
      logic [7:0] code, dbyte;
      bit valid, req_seen, done, inj_pend;
      int exp_high, high, first_c, fall_cyc, t0;
      valid = 1'b0;
      exp_high = 0;
      if (cmd > 8'h02) begin
         code = 8'hFE; dbyte = 8'h00;
      end else if (addr >= NS) begin
         code = 8'hFF; dbyte = 8'h00;
      end else begin
         valid = 1'b1;
         if (ack_after == 0) begin
            code = 8'h1F; dbyte = 8'h00; exp_high = RT;
         end else if (err) begin
            code = 8'h1F; dbyte = 8'h00; exp_high = ack_after;
         end else begin
            code = cmd; dbyte = data; exp_high = ack_after;
         end
      end
      dv_cycs.delete();
      done_cycs.delete();
      exp_q.push_back(code);
      exp_q.push_back(dbyte);

      send_byte(cmd);
      repeat (gap) @(negedge Clock);
      send_byte(addr);
      t0 = cyc;
      checks++;
      if (o_Busy !== 1'b0) begin
         errors++;
         $display("FAIL busy_lag got %b want 0", o_Busy);
      end
      @(negedge Clock);
      checks++;
      if (o_Busy !== 1'b1 || o_Sensor_Req !== 1'b0) begin
         errors++;
         $display("FAIL busy_rise got busy=%b req=%b want busy=1 req=0", o_Busy, o_Sensor_Req);
      end

      high = 0; first_c = -1; fall_cyc = -1;
      if (valid) begin
         for (int c = 0; c < RT + 20; c++) begin
            @(negedge Clock);
            i_Sensor_Ack = 1'b0;
            i_Rx_DV      = 1'b0;
            if (o_Sensor_Req === 1'b1) begin
               if (first_c < 0) begin
                  first_c = c;
                  checks++;
                  if (o_Sensor_Addr !== addr[4:0] || o_Sensor_Cmd !== cmd) begin
                     errors++;
                     $display("FAIL sensor_bus got addr=%0d cmd=%02h want addr=%0d cmd=%02h",
                              o_Sensor_Addr, o_Sensor_Cmd, addr[4:0], cmd);
                  end
               end
               high++;
               if (inject && high == 3) begin
                  i_Rx_DV = 1'b1; i_Rx_Byte = 8'h01;
               end
               if (ack_after > 1 && high == ack_after - 1) begin
                  i_Sensor_Ack = 1'b1; i_Sensor_Data = data; i_Sensor_Err = err;
               end
            end else if (high > 0) begin
               fall_cyc = cyc;
               break;
            end
         end
         checks++;
         if (first_c !== 0) begin
            errors++;
            $display("FAIL req_rise got offset %0d want 0", first_c);
         end
         checks++;
         if (high !== exp_high) begin
            errors++;
            $display("FAIL req_high_cycles got %0d want %0d", high, exp_high);
         end
      end

      req_seen = 1'b0; done = 1'b0; inj_pend = 1'b0;
      for (int c = 0; c < 200; c++) begin
         @(negedge Clock);
         i_Rx_DV      = 1'b0;
         i_Sensor_Ack = 1'b0;
         if (o_Sensor_Req === 1'b1) req_seen = 1'b1;
         if (inject && !inj_pend && dv_cycs.size() == 1) begin
            inj_pend = 1'b1;
            i_Rx_DV = 1'b1; i_Rx_Byte = 8'h00;
            i_Sensor_Ack = 1'b1; i_Sensor_Data = 8'h99; i_Sensor_Err = 1'b1;
         end
         if (o_Busy === 1'b0 && !i_Tx_Active && exp_q.size() == 0) begin
            done = 1'b1;
            break;
         end
      end
      checks++;
      if (!done) begin
         errors++;
         $display("FAIL frame_complete got pending=%0d want 0 within 200 cycles", exp_q.size());
         exp_q.delete();
      end
      checks++;
      if (dv_cycs.size() !== 2) begin
         errors++;
         $display("FAIL tx_count got %0d want 2", dv_cycs.size());
      end
      if (dv_cycs.size() >= 1) begin
         checks++;
         if (dv_cycs[0] !== (valid ? fall_cyc : t0 + 2)) begin
            errors++;
            $display("FAIL first_dv_cycle got %0d want %0d", dv_cycs[0], valid ? fall_cyc : t0 + 2);
         end
      end
      if (dv_cycs.size() == 2 && done_cycs.size() >= 1) begin
         checks++;
         if (dv_cycs[1] !== done_cycs[0] + 2 + tx_extra) begin
            errors++;
            $display("FAIL second_dv_cycle got %0d want %0d", dv_cycs[1], done_cycs[0] + 2 + tx_extra);
         end
      end
      if (!valid) begin
         checks++;
         if (req_seen) begin
            errors++;
            $display("FAIL req_on_invalid got 1 want 0");
         end
      end
   endtask

   task automatic test_reset();
      repeat (2) @(negedge Clock);
      check_outputs_zero("reset_outputs");
      Reset = 1'b0;
      repeat (3) @(negedge Clock);
      check_outputs_zero("idle_outputs");
   endtask

   task automatic test_valid_read();
      do_frame(8'h01, 8'h03, 0, 10, 1'b0, 8'h2A, 1'b0);
   endtask

   task automatic test_invalid_frames();
      do_frame(8'h07, 8'h00, 0, 0, 1'b0, 8'h00, 1'b0);
      do_frame(8'h00, 8'h20, 0, 0, 1'b0, 8'h00, 1'b0);
      do_frame(8'h01, 8'hC3, 0, 0, 1'b0, 8'h00, 1'b0);
      do_frame(8'h03, 8'h40, 0, 0, 1'b0, 8'h00, 1'b0);
   endtask

   task automatic test_sensor_faults();
      do_frame(8'h02, 8'h05, 0, 0, 1'b0, 8'h00, 1'b0);
      do_frame(8'h02, 8'h05, 0, 20, 1'b1, 8'h55, 1'b0);
   endtask

   task automatic test_byte_timeout();
      bit busy_hi;
      dv_cycs.delete();
      send_byte(8'h01);
      busy_hi = 1'b0;
      repeat (BT + 10) begin
         @(negedge Clock);
         if (o_Busy === 1'b1) busy_hi = 1'b1;
      end
      checks++;
      if (busy_hi || dv_cycs.size() != 0) begin
         errors++;
         $display("FAIL byte_timeout_silent got busy=%b tx=%0d want 0 0", busy_hi, dv_cycs.size());
      end
      do_frame(8'h00, 8'h01, 0, 6, 1'b0, 8'hA5, 1'b0);
      do_frame(8'h02, 8'h09, BT - 10, 4, 1'b0, 8'h3E, 1'b0);
   endtask

   task automatic test_ignored_inputs();
      do_frame(8'h01, 8'h1F, 0, 15, 1'b0, 8'hC7, 1'b1);
   endtask

   task automatic test_ack_at_timeout();
      do_frame(8'h02, 8'h04, 0, RT, 1'b0, 8'h5A, 1'b0);
   endtask

   task automatic test_tx_backpressure();
      tx_extra = 3;
      do_frame(8'h00, 8'h00, 0, 5, 1'b0, 8'h3C, 1'b0);
      tx_extra = 0;
   endtask

   task automatic test_reset_midframe();
      dv_cycs.delete();
      send_byte(8'h01);
      send_byte(8'h02);
      for (int c = 0; c < 10; c++) begin
         @(negedge Clock);
         if (o_Sensor_Req === 1'b1) break;
      end
      repeat (3) @(negedge Clock);
      Reset = 1'b1;
      #1;
      check_outputs_zero("reset_in_wait_ack");
      @(negedge Clock);
      Reset = 1'b0;
      repeat (40) @(negedge Clock);
      checks++;
      if (dv_cycs.size() != 0 || o_Busy !== 1'b0) begin
         errors++;
         $display("FAIL abort_wait_ack got tx=%0d busy=%b want 0 0", dv_cycs.size(), o_Busy);
      end
      do_frame(8'h01, 8'h02, 0, 8, 1'b0, 8'h6B, 1'b0);

      dv_cycs.delete();
      exp_q.push_back(8'hFE);
      send_byte(8'h07);
      send_byte(8'h00);
      for (int c = 0; c < 10; c++) begin
         @(negedge Clock);
         if (dv_cycs.size() == 1) break;
      end
      @(negedge Clock);
      Reset = 1'b1;
      #1;
      check_outputs_zero("reset_in_wait0");
      @(negedge Clock);
      Reset = 1'b0;
      repeat (40) @(negedge Clock);
      checks++;
      if (dv_cycs.size() != 1 || exp_q.size() != 0) begin
         errors++;
         $display("FAIL abort_wait0 got tx=%0d pending=%0d want 1 0", dv_cycs.size(), exp_q.size());
         exp_q.delete();
      end
      do_frame(8'h02, 8'h01, 0, 7, 1'b0, 8'h81, 1'b0);
   endtask

   task automatic test_back_to_back();
      do_frame(8'h01, 8'h10, 0, 4, 1'b0, 8'h11, 1'b0);
      do_frame(8'h02, 8'h11, 0, 3, 1'b0, 8'h22, 1'b0);
   endtask

   initial begin
      Reset         = 1'b1;
      i_Rx_DV       = 1'b0;
      i_Rx_Byte     = 8'h00;
      i_Sensor_Ack  = 1'b0;
      i_Sensor_Data = 8'h00;
      i_Sensor_Err  = 1'b0;
      test_reset();
      test_valid_read();
      test_invalid_frames();
      test_sensor_faults();
      test_byte_timeout();
      test_ignored_inputs();
      test_ack_at_timeout();
      test_tx_backpressure();
      test_reset_midframe();
      test_back_to_back();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
